// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS test-signal source for the DSO loopback DAC.
// A phase accumulator drives a sine/square/triangle/saw shaper, followed by
// amplitude scaling, signed offset around midscale and saturation to 8 bits.
// New settings are held in shadow registers and switched in at a phase wrap
// so that a measured period is never built from two configurations.
module dds_wave_gen #(
   parameter int                 PHASE_W       = 32,
   parameter logic [PHASE_W-1:0] RST_FREQ_WORD = '0
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               run,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_freq_word,
   input  logic [1:0]         cfg_wave,
   input  logic [7:0]         cfg_amp,
   input  logic [7:0]         cfg_offset,
   output logic [7:0]         da_data,
   output logic               da_sync,
   output logic               cfg_pending
);

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_TRI    = 2'd2;
   localparam logic [1:0] WAVE_SAW    = 2'd3;

   // Quarter-wave sine, sampled at odd half-steps so the table is symmetric about 90 degrees
   localparam logic [6:0] SIN_Q [0:63] = '{
      7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
      7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
      7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
      7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
      7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
      7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
      7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

   cfg_state_t         state, state_nxt;
   logic               capture, apply, apply_ok;

   logic [PHASE_W-1:0] sh_freq;
   logic [1:0]         sh_wave;
   logic [7:0]         sh_amp, sh_off;

   logic [PHASE_W-1:0] acc, freq_act;
   logic [1:0]         wave_act;
   logic [7:0]         amp_act, off_act;
   logic [PHASE_W:0]   sum;
   logic               wrap_now, wrap_r;

   logic [7:0]         phase8, raw;
   logic [5:0]         sin_idx;
   logic [6:0]         tri_t, sin_m;

   logic [7:0]         r1, amp1, off1;
   logic               wrap1;
   logic signed [15:0] prod, prod2;
   logic [7:0]         off2;
   logic               wrap2;
   logic [9:0]         s10, y10;
   logic [7:0]         y_sat;

   // The carry out of the phase add marks the start of a new output period
   assign sum      = {1'b0, acc} + {1'b0, freq_act};
   assign wrap_now = run & sum[PHASE_W];

   // A stopped or zero-frequency generator never wraps, so apply at once instead of waiting
   assign apply_ok = ~run | (freq_act == '0) | wrap_now;

   // Config handshake state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= CFG_IDLE;
      else       state <= state_nxt;
   end

   // Handshake next-state and outputs: idle accepts, pending waits for the apply point
   always_comb begin
      state_nxt   = state;
      cfg_ready   = 1'b0;
      cfg_pending = 1'b0;
      capture     = 1'b0;
      apply       = 1'b0;
      case (state)
         CFG_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               capture   = 1'b1;
               state_nxt = CFG_PEND;
            end
         end
         CFG_PEND: begin
            cfg_pending = 1'b1;
            if (apply_ok) begin
               apply     = 1'b1;
               state_nxt = CFG_IDLE;
            end
         end
         default: state_nxt = CFG_IDLE;
      endcase
   end

   // Shadow registers hold an accepted configuration until its apply point
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh_freq <= '0;
         sh_wave <= WAVE_SINE;
         sh_amp  <= '0;
         sh_off  <= '0;
      end else if (capture) begin
         sh_freq <= cfg_freq_word;
         sh_wave <= cfg_wave;
         sh_amp  <= cfg_amp;
         sh_off  <= cfg_offset;
      end
   end

   // Phase accumulator and active config; a wrap-time apply pairs the post-wrap phase with the new settings
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc      <= '0;
         wrap_r   <= 1'b0;
         freq_act <= RST_FREQ_WORD;
         wave_act <= WAVE_SINE;
         amp_act  <= '0;
         off_act  <= '0;
      end else begin
         if (run) acc <= sum[PHASE_W-1:0];
         wrap_r <= wrap_now;
         if (apply) begin
            freq_act <= sh_freq;
            wave_act <= sh_wave;
            amp_act  <= sh_amp;
            off_act  <= sh_off;
         end
      end
   end

   // Waveform shaper from the top 8 phase bits, raw sample in two's complement
   always_comb begin
      phase8  = acc[PHASE_W-1 -: 8];
      tri_t   = phase8[7] ? ~phase8[6:0] : phase8[6:0];
      sin_idx = phase8[6] ? ~phase8[5:0] : phase8[5:0];
      sin_m   = SIN_Q[sin_idx];
      raw     = 8'd0;
      case (wave_act)
         WAVE_SINE:   raw = phase8[7] ? (8'd0 - {1'b0, sin_m}) : {1'b0, sin_m};
         WAVE_SQUARE: raw = phase8[7] ? 8'h81 : 8'h7F;
         WAVE_TRI:    raw = {tri_t, 1'b0} - 8'd127;
         WAVE_SAW:    raw = phase8 ^ 8'h80;
         default:     raw = 8'd0;
      endcase
   end

   // Stage 1: raw sample, with the gain/offset/sync that belong to it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r1    <= '0;
         amp1  <= '0;
         off1  <= '0;
         wrap1 <= 1'b0;
      end else begin
         r1    <= raw;
         amp1  <= amp_act;
         off1  <= off_act;
         wrap1 <= wrap_r;
      end
   end

   assign prod = $signed({{8{r1[7]}}, r1}) * $signed({8'b0, amp1});

   // Stage 2: signed sample times unsigned gain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prod2 <= '0;
         off2  <= '0;
         wrap2 <= 1'b0;
      end else begin
         prod2 <= prod;
         off2  <= off1;
         wrap2 <= wrap1;
      end
   end

   // Floor-divide by 256, add offset around midscale, clamp to the DAC range
   always_comb begin
      s10   = 10'(prod2 >>> 8);
      y10   = s10 + {{2{off2[7]}}, off2} + 10'd128;
      y_sat = y10[9] ? 8'd0 : (y10[8] ? 8'd255 : y10[7:0]);
   end

   // Stage 3: registered DAC sample and period marker
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         da_data <= 8'd128;
         da_sync <= 1'b0;
      end else begin
         da_data <= y_sat;
         da_sync <= wrap2;
      end
   end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed bench for dds_wave_gen. The stimulus process pushes
// expected outputs, tagged with the cycle they belong to, into a scoreboard
// queue; a monitor on the falling edge pops and compares them.
module tb_dds_wave_gen;

   localparam logic [3:0] M_DATA = 4'b0001;
   localparam logic [3:0] M_SYNC = 4'b0010;
   localparam logic [3:0] M_RDY  = 4'b0100;
   localparam logic [3:0] M_PEND = 4'b1000;
   localparam logic [3:0] M_OUT  = M_DATA | M_SYNC;
   localparam logic [3:0] M_HS   = M_RDY | M_PEND;
   localparam logic [3:0] M_ALL  = 4'b1111;

   localparam int SIN_TAB [64] = '{
      2, 5, 8, 11, 14, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44, 47,
      50, 53, 56, 58, 61, 64, 67, 69, 72, 74, 77, 79, 82, 84, 86, 89,
      91, 93, 95, 97, 99, 101, 103, 105, 106, 108, 110, 111, 113, 114, 115, 117,
      118, 119, 120, 121, 122, 123, 124, 124, 125, 125, 126, 126, 127, 127, 127, 127
   };

   typedef struct {
      int         cyc;
      logic [3:0] mask;
      logic [7:0] data;
      logic       sync;
      logic       rdy;
      logic       pend;
      string      name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        run;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_freq_word;
   logic [1:0]  cfg_wave;
   logic [7:0]  cfg_amp;
   logic [7:0]  cfg_offset;
   logic [7:0]  da_data;
   logic        da_sync;
   logic        cfg_pending;

   int   cyc = 0;
   int   vectors = 0;
   int   misses = 0;
   exp_t sb[$];

   dds_wave_gen #(.PHASE_W(32), .RST_FREQ_WORD(32'd0)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .run           (run),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_freq_word (cfg_freq_word),
      .cfg_wave      (cfg_wave),
      .cfg_amp       (cfg_amp),
      .cfg_offset    (cfg_offset),
      .da_data       (da_data),
      .da_sync       (da_sync),
      .cfg_pending   (cfg_pending)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Bench cycle count, used to tag scoreboard entries
   always @(posedge clk) cyc <= cyc + 1;

   // Sine reference for amp=255, offset=0
   function automatic int sine_ref(input int a);
      int q, m, r, p;
      q = ((a & 64) != 0) ? (63 - (a & 63)) : (a & 63);
      m = SIN_TAB[q];
      r = ((a & 128) != 0) ? -m : m;
      p = r * 255;
      return (p >>> 8) + 128;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input logic [3:0] mask, input int data, input logic sync,
                             input logic rdy, input logic pend, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.mask = mask;
      e.data = 8'(data);
      e.sync = sync;
      e.rdy  = rdy;
      e.pend = pend;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic apply_stimulus(input logic [1:0] wave, input logic [31:0] fw,
                                 input logic [7:0] amp, input logic [7:0] off);
      cfg_wave      = wave;
      cfg_freq_word = fw;
      cfg_amp       = amp;
      cfg_offset    = off;
      cfg_valid     = 1'b1;
      tick();
   endtask

   task automatic check_output(input exp_t e);
      logic bad;
      bad = 1'b0;
      if (e.mask[0] && (da_data !== e.data))     bad = 1'b1;
      if (e.mask[1] && (da_sync !== e.sync))     bad = 1'b1;
      if (e.mask[2] && (cfg_ready !== e.rdy))    bad = 1'b1;
      if (e.mask[3] && (cfg_pending !== e.pend)) bad = 1'b1;
      vectors++;
      if (bad) begin
         misses++;
         $display("[TB] FAIL %s cyc=%0d mask=%b: got data=%0d sync=%b ready=%b pend=%b, want data=%0d sync=%b ready=%b pend=%b",
                  e.name, e.cyc, e.mask, da_data, da_sync, cfg_ready, cfg_pending,
                  e.data, e.sync, e.rdy, e.pend);
      end
   endtask

   // Monitor: compare every expectation that belongs to the current cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) check_output(sb.pop_front());
   end

   // Watchdog so the bench can never hang
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rstn          = 1'b0;
      run           = 1'b0;
      cfg_valid     = 1'b0;
      cfg_freq_word = '0;
      cfg_wave      = '0;
      cfg_amp       = '0;
      cfg_offset    = '0;

      // Reset values held during and after reset release
      repeat (3) tick();
      expect_now(M_ALL, 128, 1'b0, 1'b1, 1'b0, "reset_hold");
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_now(M_ALL, 128, 1'b0, 1'b1, 1'b0, "post_reset");
      end

      // Sine, applied immediately while stopped, then a 256-clk period
      apply_stimulus(2'd0, 32'h0100_0000, 8'd255, 8'd0);
      cfg_valid = 1'b0;
      expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "sine_captured");
      tick();
      expect_now(M_HS, 0, 1'b0, 1'b1, 1'b0, "sine_applied");
      repeat (3) tick();
      expect_now(M_OUT, 129, 1'b0, 1'b0, 1'b0, "sine_idle_sample");
      run = 1'b1;
      for (int k = 1; k <= 768; k++) begin
         tick();
         if (k <= 515) begin
            int a;
            a = (k >= 3) ? ((k - 3) % 256) : 0;
            expect_now(M_OUT, sine_ref(a), (k > 3) && ((k - 3) % 256 == 0), 1'b0, 1'b0,
                       (a == 64) ? "sine_max" : (a == 192) ? "sine_min" : "sine_sample");
         end
      end
      run = 1'b0;

      // Square with +100 offset: positive half saturates
      apply_stimulus(2'd1, 32'h4000_0000, 8'd255, 8'd100);
      cfg_valid = 1'b0;
      expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "square_captured");
      tick();
      expect_now(M_HS, 0, 1'b0, 1'b1, 1'b0, "square_applied");
      run = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k >= 3 && k <= 18) begin
            int j;
            j = k - 3;
            expect_now(M_OUT, ((j % 4) < 2) ? 255 : 101, (j > 0) && (j % 4 == 0),
                       1'b0, 1'b0, "square_sample");
         end
      end
      run = 1'b0;

      // Saw running; triangle offered mid-period waits for the wrap
      apply_stimulus(2'd3, 32'h0200_0000, 8'd255, 8'd0);
      cfg_valid = 1'b0;
      expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "saw_captured");
      tick();
      expect_now(M_HS, 0, 1'b0, 1'b1, 1'b0, "saw_applied");
      run = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         case (k)
            3:   expect_now(M_OUT, 0,   1'b0, 1'b0, 1'b0, "saw_start");
            40: begin
               cfg_wave      = 2'd2;
               cfg_freq_word = 32'h0200_0000;
               cfg_amp       = 8'd255;
               cfg_offset    = 8'd0;
               cfg_valid     = 1'b1;
            end
            41: begin
               expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "tri_captured");
               cfg_wave = 2'd1;
            end
            58:  cfg_valid = 1'b0;
            67:  expect_now(M_OUT, 128, 1'b0, 1'b0, 1'b0, "saw_mid");
            127: expect_now(M_HS, 0,   1'b0, 1'b0, 1'b1, "tri_wait_wrap");
            128: expect_now(M_HS, 0,   1'b0, 1'b1, 1'b0, "tri_applied_at_wrap");
            130: expect_now(M_OUT, 253, 1'b0, 1'b0, 1'b0, "saw_last");
            131: expect_now(M_OUT, 1,   1'b1, 1'b0, 1'b0, "tri_first_sync");
            132: expect_now(M_OUT, 5,   1'b0, 1'b0, 1'b0, "tri_second");
            195: expect_now(M_OUT, 254, 1'b0, 1'b0, 1'b0, "tri_peak");
            default: ;
         endcase
      end
      run = 1'b0;

      // Triangle at half gain with -128 offset: trough clamps to 0, peak 63
      apply_stimulus(2'd2, 32'h0200_0000, 8'd128, 8'h80);
      cfg_valid = 1'b0;
      expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "tri_half_captured");
      tick();
      expect_now(M_HS, 0, 1'b0, 1'b1, 1'b0, "tri_half_applied");
      run = 1'b1;
      for (int k = 1; k <= 130; k++) begin
         tick();
         case (k - 3)
            0:   expect_now(M_OUT, 0,  1'b0, 1'b0, 1'b0, "tri_half_trough");
            32:  expect_now(M_OUT, 0,  1'b0, 1'b0, 1'b0, "tri_half_r1");
            48:  expect_now(M_OUT, 32, 1'b0, 1'b0, 1'b0, "tri_half_r65");
            63:  expect_now(M_OUT, 62, 1'b0, 1'b0, 1'b0, "tri_half_r125");
            64:  expect_now(M_OUT, 63, 1'b0, 1'b0, 1'b0, "tri_half_peak");
            65:  expect_now(M_OUT, 61, 1'b0, 1'b0, 1'b0, "tri_half_r123");
            96:  expect_now(M_OUT, 0,  1'b0, 1'b0, 1'b0, "tri_half_rm1");
            127: expect_now(M_OUT, 0,  1'b0, 1'b0, 1'b0, "tri_half_rm125");
            default: ;
         endcase
      end

      // Reset while running with a pending config
      apply_stimulus(2'd1, 32'h0100_0000, 8'd255, 8'd0);
      cfg_valid = 1'b0;
      expect_now(M_HS, 0, 1'b0, 1'b0, 1'b1, "pending_before_reset");
      tick();
      rstn = 1'b0;
      expect_now(M_ALL, 128, 1'b0, 1'b1, 1'b0, "async_reset");
      tick();
      expect_now(M_ALL, 128, 1'b0, 1'b1, 1'b0, "reset_held_running");
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_now(M_ALL, 128, 1'b0, 1'b1, 1'b0, "pending_discarded");
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
         vectors += sb.size();
         misses  += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
